sccb_slave_regfile: RTL and testbench

- SCCB/I2C responder (slave) holding a 256x8 register file, for use as the target-side model of the camera configuration bus.
- Sits on the SCL/SDA lines driven by the camera-config master. Lets the master's write and read sequences be checked in simulation.
- Also usable on-chip as a configuration target for an FPGA-side peripheral.
- Oversampled design: SCL/SDA are sampled by iCLK, which must run at least 16x the SCL rate.

---
 rtl/sccb_slave_regfile.sv | 270 +++++++++++++++++++++++++++
 tb/tb_sccb_slave_regfile.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_slave_regfile.sv
// SCCB/I2C target holding a 256x8 register file behind an auto-incrementing sub-address pointer.
// SCL/SDA are oversampled by iCLK; SDA is only ever driven low (open-drain) and changes only after SCL falls.
module sccb_slave_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h21,
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  input  logic       I2C_SDAT_IN,
  output logic       I2C_SDAT_OE,
  output logic       REG_WR,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  input  logic [7:0] DBG_ADDR,
  output logic [7:0] DBG_DATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV,
    S_DEV_ACK,
    S_SUB,
    S_SUB_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_MACK,
    S_IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] scl_sync_q, scl_sync_d;
  logic [2:0] sda_sync_q, sda_sync_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       reg_wr_q, reg_wr_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic [7:0] regs_q [256];

  logic       scl, scl_prev, sda, sda_prev;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte, ptr_inc, rd_byte, rd_next;

  // Bits [1:0] synchronize, bit 2 holds the previous synchronized level for edge detection.
  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], I2C_SCLK};
    sda_sync_d = {sda_sync_q[1:0], I2C_SDAT_IN};
  end

  assign scl       = scl_sync_q[1];
  assign scl_prev  = scl_sync_q[2];
  assign sda       = sda_sync_q[1];
  assign sda_prev  = sda_sync_q[2];
  assign scl_rise  = scl & ~scl_prev;
  assign scl_fall  = ~scl & scl_prev;
  assign start_det = scl & scl_prev & sda_prev & ~sda;
  assign stop_det  = scl & scl_prev & ~sda_prev & sda;

  assign rx_byte = {shift_q[6:0], sda};
  assign ptr_inc = ptr_q + 8'd1;
  assign rd_byte = regs_q[ptr_q];
  assign rd_next = regs_q[ptr_inc];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    reg_wr_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;

    if (start_det) begin
      state_d   = S_DEV;
      bit_cnt_d = 4'd0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_IGNORE: begin
        end

        S_DEV: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_d = S_DEV_ACK;
                rw_d    = rx_byte[0];
                busy_d  = 1'b1;
              end else begin
                state_d = S_IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        // ACK states: first SCL fall pulls SDA low, second one ends the ACK bit.
        S_DEV_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else if (rw_q) begin
              state_d   = S_RDATA;
              oe_d      = ~rd_byte[7];
              shift_d   = {rd_byte[6:0], 1'b0};
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = S_SUB;
              oe_d      = 1'b0;
              bit_cnt_d = 4'd0;
            end
          end
        end

        S_SUB: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              ptr_d     = rx_byte;
              state_d   = S_SUB_ACK;
            end
          end
        end

        S_SUB_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              state_d   = S_WDATA;
              bit_cnt_d = 4'd0;
            end
          end
        end

        S_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d   = 4'd0;
              reg_wr_d    = 1'b1;
              reg_addr_d  = ptr_q;
              reg_wdata_d = rx_byte;
              state_d     = S_WDATA_ACK;
            end
          end
        end

        S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              ptr_d     = ptr_inc;
              state_d   = S_WDATA;
              bit_cnt_d = 4'd0;
            end
          end
        end

        // bit_cnt counts bits already put on SDA; the fall after the 8th releases the line.
        S_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = S_MACK;
            end else begin
              oe_d      = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        // Every byte sent advances the pointer, whether the master ACKs it or not.
        S_MACK: begin
          if (scl_rise) begin
            ptr_d = ptr_inc;
            if (!sda) begin
              shift_d   = rd_next;
              bit_cnt_d = 4'd0;
              state_d   = S_RDATA;
            end else begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Bus lines idle high, so the synchronizers reset high to avoid a false START after reset.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= S_IDLE;
      scl_sync_q  <= 3'b111;
      sda_sync_q  <= 3'b111;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 8'h00;
      rw_q        <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 256; i++) begin
        regs_q[i] <= REG_INIT;
      end
    end else if (reg_wr_d) begin
      regs_q[reg_addr_d] <= reg_wdata_d;
    end
  end

  assign I2C_SDAT_OE = oe_q;
  assign REG_WR      = reg_wr_q;
  assign REG_ADDR    = reg_addr_q;
  assign REG_WDATA   = reg_wdata_q;
  assign BUSY        = busy_q;
  assign DBG_DATA    = regs_q[DBG_ADDR];

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Bit-banged SCCB master driving sccb_slave_regfile, checked against an array-and-pointer model of the target.
module tb_sccb_slave_regfile;

  localparam int         Q           = 8;
  localparam logic [7:0] REG_INIT_TB = 8'h00;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic       sclM, sdaM;
  logic       sdaLine;
  logic       I2C_SDAT_OE, REG_WR, BUSY;
  logic [7:0] REG_ADDR, REG_WDATA, DBG_ADDR, DBG_DATA;

  int testsRun  = 0;
  int failCount = 0;
  int glitches  = 0;
  logic oeSeen  = 1'b0;
  logic sclPrev = 1'b1;
  logic oePrev  = 1'b0;

  logic [7:0]  modelMem [256];
  logic [7:0]  modelPtr;
  logic [7:0]  wbuf [$];
  logic [15:0] gotWr [$];
  logic [15:0] expWr [$];

  assign sdaLine = sdaM & ~I2C_SDAT_OE;

  always #5 iCLK = ~iCLK;

  sccb_slave_regfile #(
    .DEV_ADDR (7'h21),
    .REG_INIT (REG_INIT_TB)
  ) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .I2C_SCLK    (sclM),
    .I2C_SDAT_IN (sdaLine),
    .I2C_SDAT_OE (I2C_SDAT_OE),
    .REG_WR      (REG_WR),
    .REG_ADDR    (REG_ADDR),
    .REG_WDATA   (REG_WDATA),
    .DBG_ADDR    (DBG_ADDR),
    .DBG_DATA    (DBG_DATA),
    .BUSY        (BUSY)
  );

  // Collects write strobes, notes any SDA drive, and counts SDA changes while SCL is held high.
  always @(negedge iCLK) begin
    if (REG_WR === 1'b1) gotWr.push_back({REG_ADDR, REG_WDATA});
    if (I2C_SDAT_OE === 1'b1) oeSeen = 1'b1;
    if (sclM && sclPrev && (I2C_SDAT_OE !== oePrev)) glitches++;
    sclPrev = sclM;
    oePrev  = I2C_SDAT_OE;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic scl, input logic sda, input int cycles);
    sclM = scl;
    sdaM = sda;
    repeat (cycles) @(negedge iCLK);
  endtask

  task automatic i2cStart();
    if (sclM == 1'b0) begin
      applyStimulus(1'b0, 1'b1, Q);
      applyStimulus(1'b1, 1'b1, Q);
    end else begin
      applyStimulus(1'b1, 1'b1, Q);
    end
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b0, 1'b0, Q);
  endtask

  task automatic i2cStop();
    applyStimulus(1'b0, 1'b0, Q);
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b1, 1'b1, 2 * Q);
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(1'b0, b, Q);
    applyStimulus(1'b1, b, 2 * Q);
    applyStimulus(1'b0, b, Q);
  endtask

  task automatic recvBit(output logic b);
    applyStimulus(1'b0, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, Q);
    b = sdaLine;
    applyStimulus(1'b1, 1'b1, Q);
    applyStimulus(1'b0, 1'b1, Q);
  endtask

  task automatic writeByte(input logic [7:0] data, output logic ack);
    for (int i = 7; i >= 0; i--) sendBit(data[i]);
    recvBit(ack);
  endtask

  task automatic readByte(input logic masterAck, output logic [7:0] data);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recvBit(b);
      data[i] = b;
    end
    sendBit(masterAck);
  endtask

  task automatic checkDbg(input logic [7:0] a);
    DBG_ADDR = a;
    #1;
    checkOutput("dbg_data", {8'h00, DBG_DATA}, {8'h00, modelMem[a]});
  endtask

  // Full write transaction with the bytes in wbuf; an empty wbuf only moves the pointer.
  task automatic doWrite(input logic [7:0] sub);
    logic ack;
    i2cStart();
    writeByte(8'h42, ack);
    checkOutput("dev_w_ack", {15'd0, ack}, 16'd0);
    checkOutput("busy_set", {15'd0, BUSY}, 16'd1);
    writeByte(sub, ack);
    checkOutput("sub_ack", {15'd0, ack}, 16'd0);
    modelPtr = sub;
    foreach (wbuf[i]) begin
      writeByte(wbuf[i], ack);
      checkOutput("data_ack", {15'd0, ack}, 16'd0);
      modelMem[modelPtr] = wbuf[i];
      expWr.push_back({modelPtr, wbuf[i]});
      modelPtr = modelPtr + 8'd1;
    end
    i2cStop();
    checkOutput("busy_clr", {15'd0, BUSY}, 16'd0);
    checkOutput("wr_count", 16'(gotWr.size()), 16'(expWr.size()));
    while (gotWr.size() > 0 && expWr.size() > 0) begin
      checkOutput("wr_strobe", gotWr.pop_front(), expWr.pop_front());
    end
    gotWr.delete();
    expWr.delete();
  endtask

  // Read address phase plus n data bytes, ACKing all but the last.
  task automatic readCheck(input int n);
    logic ack;
    logic [7:0] d;
    writeByte(8'h43, ack);
    checkOutput("dev_r_ack", {15'd0, ack}, 16'd0);
    for (int i = 0; i < n; i++) begin
      readByte((i == n - 1) ? 1'b1 : 1'b0, d);
      checkOutput("rd_data", {8'h00, d}, {8'h00, modelMem[modelPtr]});
      modelPtr = modelPtr + 8'd1;
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] sub;
    int         n;

    iRST_N   = 1'b0;
    sclM     = 1'b1;
    sdaM     = 1'b1;
    DBG_ADDR = 8'h00;
    for (int i = 0; i < 256; i++) modelMem[i] = REG_INIT_TB;
    modelPtr = 8'h00;
    repeat (5) @(negedge iCLK);

    checkOutput("rst_oe", {15'd0, I2C_SDAT_OE}, 16'd0);
    checkOutput("rst_wr", {15'd0, REG_WR}, 16'd0);
    checkOutput("rst_addr", {8'h00, REG_ADDR}, 16'd0);
    checkOutput("rst_wdata", {8'h00, REG_WDATA}, 16'd0);
    checkOutput("rst_busy", {15'd0, BUSY}, 16'd0);
    iRST_N = 1'b1;
    repeat (5) @(negedge iCLK);
    checkDbg(8'h12);
    checkDbg(8'hFF);

    $display("[TB] single write 0x12=0x80");
    wbuf = '{8'h80};
    doWrite(8'h12);
    checkDbg(8'h12);

    $display("[TB] two-phase read of 0x3A");
    wbuf.delete();
    doWrite(8'h3A);
    i2cStart();
    readCheck(1);
    i2cStop();

    $display("[TB] burst write across the pointer wrap");
    wbuf = '{8'h11, 8'h22, 8'h33};
    doWrite(8'hFE);
    checkDbg(8'hFE);
    checkDbg(8'hFF);
    checkDbg(8'h00);
    wbuf.delete();
    doWrite(8'hFE);
    i2cStart();
    readCheck(3);
    i2cStop();

    $display("[TB] wrong device address");
    oeSeen = 1'b0;
    gotWr.delete();
    i2cStart();
    writeByte(8'h60, ack);
    checkOutput("wrong_addr_nack", {15'd0, ack}, 16'd1);
    checkOutput("wrong_addr_busy", {15'd0, BUSY}, 16'd0);
    writeByte(8'h12, ack);
    checkOutput("wrong_sub_nack", {15'd0, ack}, 16'd1);
    writeByte(8'h99, ack);
    checkOutput("wrong_data_nack", {15'd0, ack}, 16'd1);
    i2cStop();
    checkOutput("wrong_addr_oe", {15'd0, oeSeen}, 16'd0);
    checkOutput("wrong_addr_wr", 16'(gotWr.size()), 16'd0);
    checkDbg(8'h12);

    $display("[TB] repeated START read of 0x05..0x06");
    wbuf = '{8'hA5, 8'h5A, 8'hC3};
    doWrite(8'h05);
    i2cStart();
    writeByte(8'h42, ack);
    checkOutput("sr_dev_ack", {15'd0, ack}, 16'd0);
    writeByte(8'h05, ack);
    checkOutput("sr_sub_ack", {15'd0, ack}, 16'd0);
    modelPtr = 8'h05;
    i2cStart();
    readCheck(2);
    i2cStop();
    i2cStart();
    readCheck(1);
    i2cStop();

    $display("[TB] randomized write/read-back");
    for (int t = 0; t < 6; t++) begin
      sub = 8'($urandom_range(0, 255));
      n   = $urandom_range(0, 3);
      wbuf.delete();
      for (int k = 0; k < n; k++) wbuf.push_back(8'($urandom));
      doWrite(sub);
      wbuf.delete();
      doWrite(sub);
      i2cStart();
      readCheck($urandom_range(1, 3));
      i2cStop();
      checkDbg(sub);
      checkDbg(8'($urandom_range(0, 255)));
    end

    $display("[TB] reset while driving read data");
    wbuf = '{8'h55};
    doWrite(8'h40);
    wbuf.delete();
    doWrite(8'h40);
    i2cStart();
    writeByte(8'h43, ack);
    checkOutput("rst_rd_ack", {15'd0, ack}, 16'd0);
    checkOutput("rst_rd_oe_on", {15'd0, I2C_SDAT_OE}, 16'd1);
    #2;
    iRST_N = 1'b0;
    #1;
    checkOutput("rst_rd_oe_off", {15'd0, I2C_SDAT_OE}, 16'd0);
    checkOutput("rst_rd_busy", {15'd0, BUSY}, 16'd0);
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    for (int i = 0; i < 256; i++) modelMem[i] = REG_INIT_TB;
    modelPtr = 8'h00;
    gotWr.delete();
    applyStimulus(1'b0, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, 2 * Q);
    checkDbg(8'h40);
    wbuf = '{8'h77};
    doWrite(8'h33);
    checkDbg(8'h33);

    checkOutput("scl_high_glitch", 16'(glitches), 16'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
